// File: rtl/rgb_intensity_mixer.sv
// RGB intensity mixer: scales ADC colour codes by an intensity code with a bit-serial
// shift-add multiplier and drives three PWM outputs through period-aligned duty registers.
module rgb_intensity_mixer #(
    parameter int unsigned CW = 8,
    parameter int unsigned IW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] red_value,
    input  logic [CW-1:0] green_value,
    input  logic [CW-1:0] blue_value,
    input  logic [IW-1:0] intensity_value,
    input  logic          sample_valid,
    output logic          busy,
    output logic          overrun,
    output logic          update,
    output logic          pwm_red,
    output logic          pwm_green,
    output logic          pwm_blue
);
    localparam int unsigned PW = CW + IW + 1;
    localparam int unsigned BW = $clog2(IW + 1);
    localparam logic [BW-1:0] BitLast = BW'(IW);
    localparam logic [CW-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0][CW-1:0]  col_q, col_d;
    logic [IW-1:0]       int_q, int_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [1:0]          ch_q, ch_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [2:0][CW-1:0]  pend_q, pend_d;
    logic [2:0][CW-1:0]  act_q, act_d;
    logic                pv_q, pv_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          pwm_q, pwm_d;
    logic                upd_q, upd_d;
    logic                ovr_q, ovr_d;

    logic [IW:0]         mult;
    logic [CW-1:0]       colour;
    logic [PW-1:0]       addend;
    logic [PW-1:0]       acc_sum;
    logic [CW-1:0]       scaled;
    logic                reload;

    // Datapath for one shift-add step of the current channel.
    always_comb begin
        mult = {1'b0, int_q} + {{IW{1'b0}}, 1'b1};
        case (ch_q)
            2'd1:    colour = col_q[1];
            2'd2:    colour = col_q[2];
            default: colour = col_q[0];
        endcase
        addend  = mult[bit_q] ? (PW'(colour) << bit_q) : '0;
        acc_sum = acc_q + addend;
        scaled  = (int_q == '0) ? '0 : CW'(acc_sum >> IW);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        int_d   = int_q;
        acc_d   = acc_q;
        ch_d    = ch_q;
        bit_d   = bit_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            StIdle: begin
                if (sample_valid) begin
                    col_d   = {blue_value, green_value, red_value};
                    int_d   = intensity_value;
                    acc_d   = '0;
                    ch_d    = 2'd0;
                    bit_d   = '0;
                    state_d = StMul;
                end
            end
            StMul: begin
                acc_d = acc_sum;
                bit_d = bit_q + BW'(1);
                if (bit_q == BitLast) begin
                    case (ch_q)
                        2'd1:    pend_d[1] = scaled;
                        2'd2:    pend_d[2] = scaled;
                        default: pend_d[0] = scaled;
                    endcase
                    if (ch_q == 2'd2) begin
                        state_d = StDone;
                    end else begin
                        ch_d  = ch_q + 2'd1;
                        bit_d = '0;
                        acc_d = '0;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (sample_valid && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end
    end

    // Duties only move at the wrap edge so every PWM period is built from one duty set.
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        reload = (cnt_q == CntMax) && pv_q;
        act_d  = reload ? pend_q : act_q;
        pv_d   = reload ? 1'b0 : pv_q;
        if (state_q == StDone) begin
            pv_d = 1'b1;
        end
        upd_d = reload;
        for (int i = 0; i < 3; i++) begin
            pwm_d[i] = (cnt_d < act_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            col_q   <= '0;
            int_q   <= '0;
            acc_q   <= '0;
            ch_q    <= '0;
            bit_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            pv_q    <= 1'b0;
            cnt_q   <= '0;
            pwm_q   <= '0;
            upd_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            int_q   <= int_d;
            acc_q   <= acc_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            pv_q    <= pv_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            upd_q   <= upd_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign overrun   = ovr_q;
    assign update    = upd_q;
    assign pwm_red   = pwm_q[0];
    assign pwm_green = pwm_q[1];
    assign pwm_blue  = pwm_q[2];

endmodule

// File: tb/tb_rgb_intensity_mixer.sv
// Directed bench for rgb_intensity_mixer: table of colour/intensity vectors with
// hand-computed duties, plus overrun, latest-wins and mid-sequence reset sequences.
module tb_rgb_intensity_mixer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] red_value, green_value, blue_value;
    logic [5:0] intensity_value;
    logic       sample_valid;
    logic       busy, overrun, update, pwm_red, pwm_green, pwm_blue;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [5:0] i;
        logic [7:0] er;
        logic [7:0] eg;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    rgb_intensity_mixer #(.CW(8), .IW(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .red_value      (red_value),
        .green_value    (green_value),
        .blue_value     (blue_value),
        .intensity_value(intensity_value),
        .sample_valid   (sample_valid),
        .busy           (busy),
        .overrun        (overrun),
        .update         (update),
        .pwm_red        (pwm_red),
        .pwm_green      (pwm_green),
        .pwm_blue       (pwm_blue)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        red_value       = v.r;
        green_value     = v.g;
        blue_value      = v.b;
        intensity_value = v.i;
    endtask

    // Strobe at a negedge; return how many negedges busy stays high afterwards.
    task automatic strobe(input vec_t v, output int bc);
        drive(v);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            bc++;
            @(negedge clk);
        end
    endtask

    task automatic wait_update(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk);
            if (update === 1'b1) seen = 1'b1;
        end
        check("update_seen", int'(seen), 1);
    endtask

    // Called on the negedge where update is high (counter == 0).
    task automatic measure(input string tag, input int er, input int eg, input int eb);
        int err_r = 0, err_g = 0, err_b = 0, hi_r = 0, upd = 0;
        for (int k = 0; k < 256; k++) begin
            if (pwm_red !== (k < er)) err_r++;
            if (pwm_green !== (k < eg)) err_g++;
            if (pwm_blue !== (k < eb)) err_b++;
            if (pwm_red === 1'b1) hi_r++;
            if (k > 0 && update !== 1'b0) upd++;
            if (k < 255) @(negedge clk);
        end
        check({tag, "_red_pattern_errs"}, err_r, 0);
        check({tag, "_green_pattern_errs"}, err_g, 0);
        check({tag, "_blue_pattern_errs"}, err_b, 0);
        check({tag, "_red_high_cycles"}, hi_r, er);
        check({tag, "_extra_update"}, upd, 0);
        @(negedge clk);
        check({tag, "_no_repeat_reload"}, int'(update), 0);
    endtask

    task automatic idle_check(input string tag, input int n);
        int e_pwm = 0, e_busy = 0, e_upd = 0, e_ovr = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if ({pwm_red, pwm_green, pwm_blue} !== 3'b000) e_pwm++;
            if (busy !== 1'b0) e_busy++;
            if (update !== 1'b0) e_upd++;
            if (overrun !== 1'b0) e_ovr++;
        end
        check({tag, "_pwm_high"}, e_pwm, 0);
        check({tag, "_busy_high"}, e_busy, 0);
        check({tag, "_update_high"}, e_upd, 0);
        check({tag, "_overrun_high"}, e_ovr, 0);
    endtask

    initial begin
        int   bc;
        bit   seen;
        vec_t va, vb;

        //           r        g       b       i      er      eg      eb
        vecs[0] = {8'd255, 8'd255, 8'd255, 6'd63, 8'd255, 8'd255, 8'd255};
        vecs[1] = {8'd128, 8'd64,  8'd1,   6'd31, 8'd64,  8'd32,  8'd0};
        vecs[2] = {8'd128, 8'd64,  8'd1,   6'd0,  8'd0,   8'd0,   8'd0};
        vecs[3] = {8'd200, 8'd64,  8'd1,   6'd1,  8'd6,   8'd2,   8'd0};
        vecs[4] = {8'd100, 8'd50,  8'd10,  6'd10, 8'd17,  8'd8,   8'd1};
        vecs[5] = {8'd255, 8'd0,   8'd170, 6'd62, 8'd251, 8'd0,   8'd167};
        vecs[6] = {8'd1,   8'd2,   8'd3,   6'd63, 8'd1,   8'd2,   8'd3};

        reset = 1'b1;
        sample_valid = 1'b0;
        drive('0);
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_pwm", int'({pwm_red, pwm_green, pwm_blue}), 0);
        check("rst_update", int'(update), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        idle_check("idle", 600);

        for (int v = 0; v < 7; v++) begin
            strobe(vecs[v], bc);
            check($sformatf("vec%0d_busy_cycles", v), bc, 22);
            wait_update(seen);
            if (seen) measure($sformatf("vec%0d", v), vecs[v].er, vecs[v].eg, vecs[v].eb);
        end
        check("no_overrun_yet", int'(overrun), 0);

        // Second strobe 5 cycles into the sequence is dropped and flags overrun.
        va = {8'd100, 8'd50, 8'd10, 6'd10, 8'd17, 8'd8, 8'd1};
        vb = {8'd255, 8'd255, 8'd255, 6'd63, 8'd255, 8'd255, 8'd255};
        drive(va);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        drive(vb);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("overrun_set", int'(overrun), 1);
        for (int n = 0; n < 100 && busy === 1'b1; n++) @(negedge clk);
        check("overrun_busy_done", int'(busy), 0);
        wait_update(seen);
        if (seen) measure("ovr", va.er, va.eg, va.eb);
        check("overrun_sticky", int'(overrun), 1);

        // Two accepted samples within one period: the later one wins.
        va = {8'd128, 8'd64, 8'd1, 6'd31, 8'd64, 8'd32, 8'd0};
        vb = {8'd200, 8'd64, 8'd1, 6'd1, 8'd6, 8'd2, 8'd0};
        strobe(va, bc);
        check("latest_a_busy", bc, 22);
        check("latest_no_early_update", int'(update), 0);
        strobe(vb, bc);
        check("latest_b_busy", bc, 22);
        wait_update(seen);
        if (seen) measure("latest", vb.er, vb.eg, vb.eb);

        // Reset ten cycles into the multiply aborts everything.
        drive(vecs[0]);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_overrun", int'(overrun), 0);
        check("abort_update", int'(update), 0);
        check("abort_pwm", int'({pwm_red, pwm_green, pwm_blue}), 0);
        reset = 1'b0;
        idle_check("post_abort", 600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
